// File: rtl/rgb_seq_pkg.sv
// Shared types and helpers for the RGB hue sequencer.
// RGB_GAMMA_EN enables the square-law duty correction helper.
package rgb_seq_pkg;

  typedef enum logic [2:0] {
    SEG_RY = 3'd0,
    SEG_YG = 3'd1,
    SEG_GC = 3'd2,
    SEG_CB = 3'd3,
    SEG_BM = 3'd4,
    SEG_MR = 3'd5
  } hue_seg_e;

  localparam int unsigned NUM_SEGMENTS = 6;

`ifdef RGB_GAMMA_EN
  // Square-law correction for widths up to 16 bits; full scale stays full scale.
  function automatic logic [15:0] gamma_sq(input logic [15:0] v, input int unsigned bits);
    logic [31:0] prod;
    logic [15:0] max_v;
    max_v = 16'((32'd1 << bits) - 32'd1);
    prod  = 32'(v) * 32'(v);
    return (v == max_v) ? max_v : 16'(prod >> bits);
  endfunction
`endif

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty register loaded at the period boundary and a registered compare.
module pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MaxVal = '1;

  logic [PWM_BITS-1:0] duty_q;
  logic                cmp;
  logic                out_q;

  // Full-scale duty is forced on so the LED never drops out for the MAX count.
  always_comb begin
    cmp = 1'b0;
    if (duty_q == MaxVal) begin
      cmp = 1'b1;
    end else if (duty_q != '0) begin
      cmp = (pwm_cnt < duty_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      out_q  <= 1'b0;
    end else begin
      if (load) begin
        duty_q <= target;
      end
      out_q <= cmp & enable;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel fade sequencer driving three active-high PWM channels.
// Define RGB_GAMMA_EN for square-law duty correction; default is linear.
module rgb_hue_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 46875
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hold,
  output logic       red_pwm,
  output logic       green_pwm,
  output logic       blue_pwm,
  output logic [2:0] segment,
  output logic       seg_done
);

  localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] MaxVal = '1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
  localparam logic [2:0] SegLast = 3'(NUM_SEGMENTS - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [StepW-1:0]    step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [2:0]          segment_q, segment_d;
  logic                seg_done_q, seg_done_d;

  logic period_end;
  logic run;
  logic tick;

  logic [PWM_BITS-1:0] rise, fall;
  logic [PWM_BITS-1:0] r_lin, g_lin, b_lin;
  logic [PWM_BITS-1:0] r_tgt, g_tgt, b_tgt;

  assign period_end = (pwm_cnt_q == MaxVal);
  assign run        = enable & ~hold;
  assign tick       = run & (step_cnt_q == StepLast);

  always_comb begin
    step_cnt_d = step_cnt_q;
    level_d    = level_q;
    segment_d  = segment_q;
    seg_done_d = 1'b0;
    if (run) begin
      if (tick) begin
        step_cnt_d = '0;
        if (level_q != MaxVal) begin
          level_d = level_q + PWM_BITS'(1);
        end else begin
          level_d    = '0;
          segment_d  = (segment_q == SegLast) ? 3'd0 : segment_q + 3'd1;
          seg_done_d = 1'b1;
        end
      end else begin
        step_cnt_d = step_cnt_q + StepW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      level_q    <= '0;
      segment_q  <= 3'd0;
      seg_done_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
      step_cnt_q <= step_cnt_d;
      level_q    <= level_d;
      segment_q  <= segment_d;
      seg_done_q <= seg_done_d;
    end
  end

  // Hue table: each segment ramps exactly one channel up or down.
  always_comb begin
    rise  = level_q;
    fall  = MaxVal - level_q;
    r_lin = '0;
    g_lin = '0;
    b_lin = '0;
    case (hue_seg_e'(segment_q))
      SEG_RY: begin r_lin = MaxVal; g_lin = rise;   end
      SEG_YG: begin r_lin = fall;   g_lin = MaxVal; end
      SEG_GC: begin g_lin = MaxVal; b_lin = rise;   end
      SEG_CB: begin g_lin = fall;   b_lin = MaxVal; end
      SEG_BM: begin r_lin = rise;   b_lin = MaxVal; end
      SEG_MR: begin r_lin = MaxVal; b_lin = fall;   end
      default: ;
    endcase
  end

`ifdef RGB_GAMMA_EN
  logic [15:0] r_sq, g_sq, b_sq;
  always_comb begin
    r_sq  = gamma_sq(16'(r_lin), PWM_BITS);
    g_sq  = gamma_sq(16'(g_lin), PWM_BITS);
    b_sq  = gamma_sq(16'(b_lin), PWM_BITS);
    r_tgt = r_sq[PWM_BITS-1:0];
    g_tgt = g_sq[PWM_BITS-1:0];
    b_tgt = b_sq[PWM_BITS-1:0];
  end
`else
  assign r_tgt = r_lin;
  assign g_tgt = g_lin;
  assign b_tgt = b_lin;
`endif

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (period_end),
    .target  (r_tgt),
    .pwm_cnt (pwm_cnt_q),
    .pwm_out (red_pwm)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (period_end),
    .target  (g_tgt),
    .pwm_cnt (pwm_cnt_q),
    .pwm_out (green_pwm)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (period_end),
    .target  (b_tgt),
    .pwm_cnt (pwm_cnt_q),
    .pwm_out (blue_pwm)
  );

  assign segment  = segment_q;
  assign seg_done = seg_done_q;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Randomized bench for rgb_hue_sequencer against a cycle-count reference model.
module tb_rgb_hue_sequencer;

  localparam int unsigned N    = 3;
  localparam int unsigned MAXV = 7;
  localparam int unsigned STEP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic       red_pwm, green_pwm, blue_pwm;
  logic [2:0] segment;
  logic       seg_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: level/segment derived from the number of enabled, unheld cycles.
  int unsigned edges = 0;
  int unsigned runs = 0;
  int          mduty [3];
  bit          mout [3];
  bit          mdone = 1'b0;

  rgb_hue_sequencer #(
    .PWM_BITS    (N),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .hold      (hold),
    .red_pwm   (red_pwm),
    .green_pwm (green_pwm),
    .blue_pwm  (blue_pwm),
    .segment   (segment),
    .seg_done  (seg_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lin_target(input int ch, input int lvl, input int seg);
    int rise, fall;
    int v [3];
    rise = lvl;
    fall = MAXV - lvl;
    v[0] = 0; v[1] = 0; v[2] = 0;
    case (seg)
      0: begin v[0] = MAXV; v[1] = rise; end
      1: begin v[0] = fall; v[1] = MAXV; end
      2: begin v[1] = MAXV; v[2] = rise; end
      3: begin v[1] = fall; v[2] = MAXV; end
      4: begin v[0] = rise; v[2] = MAXV; end
      default: begin v[0] = MAXV; v[2] = fall; end
    endcase
    return v[ch];
  endfunction

  function automatic int shape(input int v);
`ifdef RGB_GAMMA_EN
    return (v == MAXV) ? MAXV : (v * v) >> N;
`else
    return v;
`endif
  endfunction

  function automatic int m_level();
    return (runs / STEP) % (MAXV + 1);
  endfunction

  function automatic int m_segment();
    return ((runs / STEP) / (MAXV + 1)) % 6;
  endfunction

  task automatic model_reset();
    edges = 0;
    runs  = 0;
    mdone = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mduty[c] = 0;
      mout[c]  = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_val("red", red_pwm, mout[0]);
    check_val("green", green_pwm, mout[1]);
    check_val("blue", blue_pwm, mout[2]);
    check_val("segment", segment, m_segment());
    check_val("seg_done", seg_done, mdone);
  endtask

  // Apply inputs, advance one clock, update the model, and compare.
  task automatic step(input bit en, input bit hd);
    int pwm_pre, lvl_pre, seg_pre, t_prev;
    enable = en;
    hold   = hd;
    @(posedge clk);
    pwm_pre = edges % (MAXV + 1);
    lvl_pre = m_level();
    seg_pre = m_segment();
    for (int c = 0; c < 3; c++) begin
      mout[c] = en && (mduty[c] == MAXV || (mduty[c] != 0 && pwm_pre < mduty[c]));
    end
    if (pwm_pre == MAXV) begin
      for (int c = 0; c < 3; c++) mduty[c] = shape(lin_target(c, lvl_pre, seg_pre));
    end
    t_prev = runs / STEP;
    if (en && !hd) runs++;
    mdone = ((runs / STEP) != t_prev) && (((runs / STEP) % (MAXV + 1)) == 0);
    edges++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_red", red_pwm, 0);
    check_val("rst_green", green_pwm, 0);
    check_val("rst_blue", blue_pwm, 0);
    check_val("rst_segment", segment, 0);
    check_val("rst_seg_done", seg_done, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int pulses;
    int stretch;
    model_reset();
    @(negedge clk);
    do_reset();

    // Full colour wheel from reset.
    pulses = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b1, 1'b0);
      if (seg_done === 1'b1) pulses++;
    end
    check_val("wheel_pulses", pulses, 6);
    check_val("wheel_segment", segment, 0);

    // Mid-period reset, then hold in S1, blank, and resume.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    check_val("hold_segment", segment, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

    // Randomized enable/hold with occasional long stretches and one async reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 777) begin
        do_reset();
      end
      stretch = $urandom_range(0, 19);
      if (stretch == 0) begin
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1);
      end else begin
        step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
- Drives the on-board RGB LED through a continuous colour-wheel fade (R→Y→G→C→B→M→R).
- Owns one free-running PWM counter shared by three per-channel comparators, a step timer, and a 6-state hue FSM that computes per-channel duty.
- Outputs are active-high; the top level inverts them for the active-low LED pins.
- Replaces a fixed-pattern controller as the sequencing layer above the PWM datapath.

Parameters:
- PWM_BITS, 8, PWM counter and duty width N; MAX = 2^N-1.
- STEP_CYCLES, 46875, clocks per one-LSB duty step (12 MHz default gives roughly 1 s per segment at N=8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run/blank. Low forces all LED outputs low and freezes the step timer, level and segment.
- hold  in  1  freezes the step timer, level and segment. PWM output continues at the current duty.
- red_pwm  out  1  red channel PWM, active-high.
- green_pwm  out  1  green channel PWM, active-high.
- blue_pwm  out  1  blue channel PWM, active-high.
- segment  out  3  current hue segment, 0..5.
- seg_done  out  1  one-cycle pulse when the segment advances.

Behaviour:
- Reset (async, any time):
  - pwm_cnt=0, step_cnt=0, level=0, segment=0.
  - Duty registers = 0.
  - All *_pwm=0, seg_done=0.
- PWM counter:
  - pwm_cnt increments every clk regardless of enable/hold and wraps MAX→0.
  - A "period boundary" is the cycle where pwm_cnt==MAX.
- Step timer:
  - Counts 0..STEP_CYCLES-1 only while enable && !hold.
  - tick is asserted when step_cnt==STEP_CYCLES-1 and step_cnt returns to 0 on the next cycle.
- On tick:
  - If level<MAX: level++.
  - Else (level==MAX): level←0, segment←(segment==5)?0:segment+1, and seg_done=1 on the following cycle.
- Hue FSM per segment. rise=level, fall=MAX-level:
  - S0: R=MAX, G=rise, B=0.
  - S1: R=fall, G=MAX, B=0.
  - S2: R=0, G=MAX, B=rise.
  - S3: R=0, G=fall, B=MAX.
  - S4: R=rise, G=0, B=MAX.
  - S5: R=MAX, G=0, B=fall.
  - Segment edges are continuous: end of Sk equals start of Sk+1. Each segment lasts (MAX+1)*STEP_CYCLES enabled, unheld cycles.
- Duty load:
  - Target duties are computed combinationally from segment/level.
  - The duty registers load them only at a period boundary. No mid-period duty change, so no glitch pulses.
- Compare (registered, 1-cycle latency from pwm_cnt):
  - duty==0 → out 0.
  - duty==MAX → out 1 every cycle (true full-on).
  - Otherwise out = (pwm_cnt < duty).
  - Final out = compare & enable.
- enable:
  - Deassertion blanks outputs on the next clk edge.
  - Reassertion resumes from the frozen level/segment/step_cnt with no restart.
- Simultaneous enable low and hold high: enable low takes precedence (blanked, frozen).
- segment output equals the segment register and changes on the tick edge.

Optional Feature:
- Macro: RGB_GAMMA_EN.
- Defined: each target duty passes through a square-law correction, duty = (v*v) >> N using a 2N-bit product. v==MAX maps to MAX (forced), so full-on is preserved.
- Undefined: duty = v (linear). No multiplier is inferred.

Decomposition:
- Package rgb_seq_pkg holds:
  - enum hue_seg_e {SEG_RY, SEG_YG, SEG_GC, SEG_CB, SEG_BM, SEG_MR} (3 bits).
  - NUM_SEGMENTS=6.
  - Function gamma_sq for RGB_GAMMA_EN.
- One natural sub-module: pwm_channel.
  - Duty register with period-boundary load, plus compare/force logic.
  - Instantiated three times, sharing the pwm_cnt input.

Test Plan (bench uses PWM_BITS=3, STEP_CYCLES=2: MAX=7, 16 cycles/segment, 8-cycle PWM period):
1. Reset release, enable=1, hold=0 → first period: red high 8/8 cycles once duty loads, green and blue 0. Assert rst_n=0 mid-period → all outputs 0 asynchronously, segment=0.
2. Run 16 enabled cycles → seg_done pulses exactly once, segment 0→1. In steady state within S0 at level=3, green is high 3 of 8 cycles per period.
3. Run 96 cycles from reset → segment sequence 0,1,2,3,4,5,0 and six seg_done pulses. Blue is 0 throughout S0–S1; red reaches 0 in S2.
4. Inject a duty change mid-period (tick at pwm_cnt=3) → output pattern changes only after pwm_cnt wraps, with no extra pulse in the current period.
5. hold=1 for 40 cycles in S1 → segment and level are unchanged and the PWM waveform repeats identically. Then enable=0 → outputs 0 next cycle. Re-enable → resumes the same level with step_cnt preserved.
6. With RGB_GAMMA_EN, N=3: level=4 gives duty (16>>3)=2, so 2/8 high; level=7 gives full-on. Without the macro, level=4 gives 4/8 high.
